lcd_panel_responder: RTL and testbench
======================================

# lcd_panel_responder

Responder end of the two-half 128x64 graphic LCD bus driven by `LCD_control`. The block decodes `LCD_en` strobes carrying `LCD_cs`/`LCD_di`/`LCD_rw`/`LCD_data`, maintains per-half panel state (display on/off, page, Y address, start line) and stores written bytes in a 1024-byte display RAM. It sits beside the LCD driver as an on-chip shadow of the panel. A read port and status outputs let a bench or debug logic check frames produced by `RAM_ctrl` → `LCD_control` without the physical panel.

## Interface
- No parameters; geometry is fixed at 2 halves x 8 pages x 64 columns.
- `clk`  in  1  same clock as the driving `LCD_control` (clk_div domain)
- `rst_n`  in  1  asynchronous, active-low reset
- `LCD_rst`  in  1  panel reset, active-low, sampled synchronously
- `LCD_cs`  in  2  half select; bit0 = left, bit1 = right; both set = both halves
- `LCD_rw`  in  1  0 = write, 1 = read
- `LCD_di`  in  1  0 = command, 1 = data
- `LCD_data`  in  8  bus byte
- `LCD_en`  in  1  strobe; transaction executes on its falling edge
- `rd_addr`  in  10  {half, page[2:0], y[5:0]}
- `rd_data`  out  8  display RAM byte at `rd_addr`, registered
- `disp_on`  out  2  per-half display-on flag
- `start_line0`, `start_line1`  out  6 each  start line per half
- `wr_pulse`  out  1  one-cycle pulse per accepted data write
- `err_pulse`  out  1  one-cycle pulse per rejected transaction
- `wr_count`  out  16  accepted data writes since reset, wraps at 65535→0

## Operation
- Strobe detect: `LCD_en` and bus registered each cycle (`en_q`, `bus_q`). Falling edge = `en_q`=1 and `LCD_en`=0; transaction uses `bus_q` (values present while `en` was high).
- Per-half state: `page` (3b), `y` (6b), `start` (6b), `on` (1b).
- Decode when `rw_q`=0, `di_q`=0, for each selected half:
  - 0x3E / 0x3F → `on` = 0 / 1.
  - 0x40–0x7F → `y` = data[5:0].
  - 0xB8–0xBF → `page` = data[2:0].
  - 0xC0–0xFF → `start` = data[5:0].
  - Anything else → no state change, `err_pulse`.
- Data write (`rw_q`=0, `di_q`=1): byte written to RAM[{half,page,y}] of each selected half; each selected half's `y` increments, 63 wraps to 0, `page` unchanged. `wr_pulse` asserted; `wr_count` +1 per transaction, including when both halves are selected.
- `rw_q`=1: no state/RAM change, `err_pulse`.
- `cs_q`=00: transaction ignored, no pulses.
- `LCD_rst`=0: all half state cleared (`on`=0, `page`=0, `y`=0, `start`=0) every cycle it is low; strobes are ignored; RAM contents and `wr_count` kept.
- RAM: 1024x8, one write port (two halves written in the same cycle when both are selected, so it is implemented as two 512x8 banks), independent read port.

## Timing
- Reset (`rst_n`=0): `rd_data`=0, `disp_on`=00, start lines 0, `wr_pulse`=0, `err_pulse`=0, `wr_count`=0, `en_q`=0, all half state 0. RAM contents are undefined after reset.
- Falling edge seen in cycle N → state/RAM updated and pulses high in cycle N+1. Pulses last exactly one cycle.
- Minimum strobe: `LCD_en` high ≥1 cycle and low ≥1 cycle. Back-to-back strobes at that rate must all execute.
- `rd_data` = RAM[`rd_addr`] one cycle after `rd_addr` is applied. A read and a write to the same address in the same cycle returns the old byte.
- `LCD_en` high when `rst_n` deasserts: no falling edge is inferred from the reset value.

## Test plan
- Init: `cs`=11, commands 0x3F, 0xC5 → `disp_on`=11, both start lines =5, no `err_pulse`.
- Write row: `cs`=01, commands 0xBA, 0x7E, then data 0xA1, 0xA2, 0xA3 → RAM[{0,2,62}]=A1, [{0,2,63}]=A2, [{0,2,0}]=A3 (wrap), `wr_count`=3, right half untouched.
- Dual select: `cs`=11, data 0x55 at page 0 y 0 → both halves hold 0x55 at y 0, both `y`=1, `wr_count` +1, one `wr_pulse`.
- Errors: command 0x12, then a strobe with `rw`=1 → two `err_pulse`, no state change. A strobe with `cs`=00 → no pulse.
- Panel reset: after setup, hold `LCD_rst`=0 for 3 cycles with a data strobe inside → `disp_on`=00, page/y 0, strobe dropped; earlier RAM bytes still readable.
- Async reset mid-burst: assert `rst_n` low while `LCD_en`=1 → all outputs 0 immediately. After release with `LCD_en` low, no spurious pulse.

Source files
------------

// File: rtl/lcd_panel_responder_if.sv
// Panel-side bus of the two-half graphic LCD: strobe, half select, control and data byte.
interface lcd_panel_responder_if;
  logic       LCD_rst;
  logic [1:0] LCD_cs;
  logic       LCD_rw;
  logic       LCD_di;
  logic [7:0] LCD_data;
  logic       LCD_en;

  modport master (
    output LCD_rst, LCD_cs, LCD_rw, LCD_di, LCD_data, LCD_en
  );

  modport slave (
    input LCD_rst, LCD_cs, LCD_rw, LCD_di, LCD_data, LCD_en
  );
endinterface

// File: rtl/lcd_panel_responder.sv
// Shadow of a two-half 128x64 graphic LCD: decodes falling-edge strobes, tracks per-half
// panel state and stores written bytes in two 512x8 banks with a registered read port.
module lcd_panel_responder (
  input  logic                        clk,
  input  logic                        rst_n,
  lcd_panel_responder_if.slave        lcd,
  input  logic [9:0]                  rd_addr,
  output logic [7:0]                  rd_data,
  output logic [1:0]                  disp_on,
  output logic [5:0]                  start_line0,
  output logic [5:0]                  start_line1,
  output logic                        wr_pulse,
  output logic                        err_pulse,
  output logic [15:0]                 wr_count
);

  typedef enum logic [2:0] {
    OP_NONE,
    OP_ON,
    OP_Y,
    OP_PAGE,
    OP_START,
    OP_WRITE,
    OP_ERR
  } op_t;

  typedef struct packed {
    logic       on;
    logic [2:0] page;
    logic [5:0] y;
    logic [5:0] start;
  } half_t;

  logic       en_q;
  logic [1:0] cs_q;
  logic       rw_q;
  logic       di_q;
  logic [7:0] data_q;
  logic       strobe;
  op_t        op;
  half_t      hs0;
  half_t      hs1;

  logic [7:0] bank0 [512];
  logic [7:0] bank1 [512];

  // A falling edge executes the bus captured while the strobe was high; panel reset masks it.
  assign strobe = en_q & ~lcd.LCD_en & lcd.LCD_rst;

  always_comb begin
    op = OP_NONE;
    if (strobe && cs_q != 2'b00) begin
      if (rw_q)                         op = OP_ERR;
      else if (di_q)                    op = OP_WRITE;
      else if (data_q[7:1] == 7'h1F)    op = OP_ON;
      else if (data_q[7:6] == 2'b01)    op = OP_Y;
      else if (data_q[7:3] == 5'b10111) op = OP_PAGE;
      else if (data_q[7:6] == 2'b11)    op = OP_START;
      else                              op = OP_ERR;
    end
  end

  function automatic half_t next_half(input half_t s, input op_t o,
                                      input logic [7:0] d, input logic sel);
    half_t n;
    n = s;
    if (sel) begin
      case (o)
        OP_ON:    n.on    = d[0];
        OP_Y:     n.y     = d[5:0];
        OP_PAGE:  n.page  = d[2:0];
        OP_START: n.start = d[5:0];
        OP_WRITE: n.y     = s.y + 6'd1;
        default:  ;
      endcase
    end
    return n;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q      <= 1'b0;
      cs_q      <= '0;
      rw_q      <= 1'b0;
      di_q      <= 1'b0;
      data_q    <= '0;
      hs0       <= '0;
      hs1       <= '0;
      wr_pulse  <= 1'b0;
      err_pulse <= 1'b0;
      wr_count  <= '0;
      rd_data   <= '0;
    end else begin
      en_q      <= lcd.LCD_en;
      cs_q      <= lcd.LCD_cs;
      rw_q      <= lcd.LCD_rw;
      di_q      <= lcd.LCD_di;
      data_q    <= lcd.LCD_data;
      wr_pulse  <= (op == OP_WRITE);
      err_pulse <= (op == OP_ERR);
      if (op == OP_WRITE)
        wr_count <= wr_count + 16'd1;
      if (!lcd.LCD_rst) begin
        hs0 <= '0;
        hs1 <= '0;
      end else begin
        hs0 <= next_half(hs0, op, data_q, cs_q[0]);
        hs1 <= next_half(hs1, op, data_q, cs_q[1]);
      end
      rd_data <= rd_addr[9] ? bank1[rd_addr[8:0]] : bank0[rd_addr[8:0]];
    end
  end

  // Separate banks so a dual-select write lands in both halves in one cycle.
  always_ff @(posedge clk) begin
    if (op == OP_WRITE) begin
      if (cs_q[0])
        bank0[{hs0.page, hs0.y}] <= data_q;
      if (cs_q[1])
        bank1[{hs1.page, hs1.y}] <= data_q;
    end
  end

  assign disp_on     = {hs1.on, hs0.on};
  assign start_line0 = hs0.start;
  assign start_line1 = hs1.start;

endmodule

// File: tb/tb_lcd_panel_responder.sv
// Directed bench for lcd_panel_responder: table of strobes with expected panel state,
// RAM read-back table, and hand-written sequences for the multi-cycle corner cases.
module tb_lcd_panel_responder;

  logic        clk;
  logic        rst_n;
  logic [9:0]  rd_addr;
  logic [7:0]  rd_data;
  logic [1:0]  disp_on;
  logic [5:0]  start_line0;
  logic [5:0]  start_line1;
  logic        wr_pulse;
  logic        err_pulse;
  logic [15:0] wr_count;

  lcd_panel_responder_if bus ();

  lcd_panel_responder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .lcd         (bus.slave),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .disp_on     (disp_on),
    .start_line0 (start_line0),
    .start_line1 (start_line1),
    .wr_pulse    (wr_pulse),
    .err_pulse   (err_pulse),
    .wr_count    (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int fails;
  int wr_seen;
  int err_seen;

  initial begin
    wr_seen  = 0;
    err_seen = 0;
  end

  // Pulse counters sampled on the inactive edge so pulse length is measured too.
  always @(negedge clk) begin
    if (wr_pulse)  wr_seen++;
    if (err_pulse) err_seen++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic strobe(input logic [1:0] cs, input logic rw, input logic di, input logic [7:0] d);
    @(posedge clk); #1;
    bus.LCD_cs = cs; bus.LCD_rw = rw; bus.LCD_di = di; bus.LCD_data = d; bus.LCD_en = 1'b1;
    @(posedge clk); #1;
    bus.LCD_en = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic read_check(input string name, input logic [9:0] a, input logic [7:0] exp);
    rd_addr = a;
    @(posedge clk); #1;
    check(name, {24'd0, rd_data}, {24'd0, exp});
  endtask

  typedef struct {
    logic [1:0]  cs;
    logic        rw;
    logic        di;
    logic [7:0]  data;
    int          wr;
    int          err;
    logic [1:0]  disp;
    logic [5:0]  s0;
    logic [5:0]  s1;
    logic [15:0] cnt;
  } vec_t;

  typedef struct {
    logic [9:0] addr;
    logic [7:0] val;
  } rd_t;

  vec_t vecs [17];
  rd_t  rds  [7];

  initial begin
    int w0, e0;
    tests = 0;
    fails = 0;

    //            cs     rw    di    data   wr err disp   s0    s1    cnt
    vecs[0]  = '{2'b11, 1'b0, 1'b0, 8'h3F, 0, 0, 2'b11, 6'd0, 6'd0, 16'd0};
    vecs[1]  = '{2'b11, 1'b0, 1'b0, 8'hC5, 0, 0, 2'b11, 6'd5, 6'd5, 16'd0};
    vecs[2]  = '{2'b01, 1'b0, 1'b0, 8'hBA, 0, 0, 2'b11, 6'd5, 6'd5, 16'd0};
    vecs[3]  = '{2'b01, 1'b0, 1'b0, 8'h7E, 0, 0, 2'b11, 6'd5, 6'd5, 16'd0};
    vecs[4]  = '{2'b01, 1'b0, 1'b1, 8'hA1, 1, 0, 2'b11, 6'd5, 6'd5, 16'd1};
    vecs[5]  = '{2'b01, 1'b0, 1'b1, 8'hA2, 1, 0, 2'b11, 6'd5, 6'd5, 16'd2};
    vecs[6]  = '{2'b01, 1'b0, 1'b1, 8'hA3, 1, 0, 2'b11, 6'd5, 6'd5, 16'd3};
    vecs[7]  = '{2'b11, 1'b0, 1'b0, 8'hB8, 0, 0, 2'b11, 6'd5, 6'd5, 16'd3};
    vecs[8]  = '{2'b11, 1'b0, 1'b0, 8'h40, 0, 0, 2'b11, 6'd5, 6'd5, 16'd3};
    vecs[9]  = '{2'b11, 1'b0, 1'b1, 8'h55, 1, 0, 2'b11, 6'd5, 6'd5, 16'd4};
    vecs[10] = '{2'b01, 1'b0, 1'b0, 8'h12, 0, 1, 2'b11, 6'd5, 6'd5, 16'd4};
    vecs[11] = '{2'b01, 1'b1, 1'b0, 8'h00, 0, 1, 2'b11, 6'd5, 6'd5, 16'd4};
    vecs[12] = '{2'b00, 1'b0, 1'b1, 8'h77, 0, 0, 2'b11, 6'd5, 6'd5, 16'd4};
    vecs[13] = '{2'b10, 1'b0, 1'b0, 8'h3E, 0, 0, 2'b01, 6'd5, 6'd5, 16'd4};
    vecs[14] = '{2'b10, 1'b0, 1'b0, 8'hC9, 0, 0, 2'b01, 6'd5, 6'd9, 16'd4};
    vecs[15] = '{2'b10, 1'b0, 1'b1, 8'h66, 1, 0, 2'b01, 6'd5, 6'd9, 16'd5};
    vecs[16] = '{2'b01, 1'b0, 1'b1, 8'h11, 1, 0, 2'b01, 6'd5, 6'd9, 16'd6};

    rds[0] = '{10'd190, 8'hA1};
    rds[1] = '{10'd191, 8'hA2};
    rds[2] = '{10'd128, 8'hA3};
    rds[3] = '{10'd0,   8'h55};
    rds[4] = '{10'd512, 8'h55};
    rds[5] = '{10'd513, 8'h66};
    rds[6] = '{10'd1,   8'h11};

    rst_n = 1'b0; rd_addr = '0;
    bus.LCD_rst = 1'b1; bus.LCD_cs = 2'b00; bus.LCD_rw = 1'b0;
    bus.LCD_di = 1'b0; bus.LCD_data = '0; bus.LCD_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_disp", {30'd0, disp_on}, 32'd0);
    check("reset_start", {20'd0, start_line0, start_line1}, 32'd0);
    check("reset_pulses", {30'd0, wr_pulse, err_pulse}, 32'd0);
    check("reset_count", {16'd0, wr_count}, 32'd0);
    check("reset_rd", {24'd0, rd_data}, 32'd0);
    #2 rst_n = 1'b1;

    foreach (vecs[i]) begin
      w0 = wr_seen; e0 = err_seen;
      strobe(vecs[i].cs, vecs[i].rw, vecs[i].di, vecs[i].data);
      check($sformatf("v%0d_wr", i), wr_seen - w0, vecs[i].wr);
      check($sformatf("v%0d_err", i), err_seen - e0, vecs[i].err);
      check($sformatf("v%0d_disp", i), {30'd0, disp_on}, {30'd0, vecs[i].disp});
      check($sformatf("v%0d_start", i), {20'd0, start_line0, start_line1},
            {20'd0, vecs[i].s0, vecs[i].s1});
      check($sformatf("v%0d_cnt", i), {16'd0, wr_count}, {16'd0, vecs[i].cnt});
    end

    foreach (rds[i])
      read_check($sformatf("ram%0d", i), rds[i].addr, rds[i].val);

    // Read and write to the same address in one cycle returns the old byte.
    strobe(2'b01, 1'b0, 1'b0, 8'h41);
    rd_addr = 10'd1;
    @(posedge clk); #1;
    bus.LCD_cs = 2'b01; bus.LCD_rw = 1'b0; bus.LCD_di = 1'b1; bus.LCD_data = 8'h22;
    bus.LCD_en = 1'b1;
    @(posedge clk); #1;
    bus.LCD_en = 1'b0;
    @(posedge clk); #1;
    check("rdw_old", {24'd0, rd_data}, 32'h11);
    @(posedge clk); #1;
    check("rdw_new", {24'd0, rd_data}, 32'h22);
    check("rdw_cnt", {16'd0, wr_count}, 32'd7);

    // Back-to-back strobes at the minimum high/low rate.
    w0 = wr_seen;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      bus.LCD_cs = 2'b10; bus.LCD_di = 1'b1; bus.LCD_data = 8'hC1 + 8'(k); bus.LCD_en = 1'b1;
      @(posedge clk); #1;
      bus.LCD_en = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    check("b2b_pulses", wr_seen - w0, 3);
    check("b2b_cnt", {16'd0, wr_count}, 32'd10);
    read_check("b2b_ram0", 10'd514, 8'hC1);
    read_check("b2b_ram1", 10'd515, 8'hC2);
    read_check("b2b_ram2", 10'd516, 8'hC3);

    // Panel reset held three cycles with a data strobe inside it.
    w0 = wr_seen; e0 = err_seen;
    @(posedge clk); #1;
    bus.LCD_rst = 1'b0; bus.LCD_cs = 2'b11; bus.LCD_di = 1'b1; bus.LCD_data = 8'h99;
    bus.LCD_en = 1'b1;
    @(posedge clk); #1;
    bus.LCD_en = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.LCD_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("prst_pulses", (wr_seen - w0) + (err_seen - e0), 0);
    check("prst_disp", {30'd0, disp_on}, 32'd0);
    check("prst_start", {20'd0, start_line0, start_line1}, 32'd0);
    check("prst_cnt", {16'd0, wr_count}, 32'd10);
    strobe(2'b01, 1'b0, 1'b1, 8'h33);
    strobe(2'b10, 1'b0, 1'b1, 8'h44);
    check("prst_cnt2", {16'd0, wr_count}, 32'd12);
    read_check("prst_left0", 10'd0, 8'h33);
    read_check("prst_right0", 10'd512, 8'h44);
    read_check("prst_kept", 10'd190, 8'hA1);

    // Asynchronous reset in the middle of a strobe.
    @(posedge clk); #1;
    bus.LCD_cs = 2'b11; bus.LCD_di = 1'b1; bus.LCD_data = 8'h5A; bus.LCD_en = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("arst_disp", {30'd0, disp_on}, 32'd0);
    check("arst_cnt", {16'd0, wr_count}, 32'd0);
    check("arst_misc", {22'd0, rd_data, wr_pulse, err_pulse}, 32'd0);
    @(posedge clk); #1;
    bus.LCD_en = 1'b0;
    #2 rst_n = 1'b1;
    w0 = wr_seen; e0 = err_seen;
    repeat (3) @(posedge clk);
    #1;
    check("arst_nopulse", (wr_seen - w0) + (err_seen - e0), 0);
    check("arst_cnt2", {16'd0, wr_count}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
